// File: rtl/ysyx_24100006_arb_pkg.sv
// ysyx_24100006_arb_pkg: shared state/owner enums and default widths for the memory arbiter
package ysyx_24100006_arb_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;
endpackage

// File: rtl/ysyx_24100006_arb_pick.sv
// ysyx_24100006_arb_pick: LSU-priority pick with bounded LSU streak
//   ifu_valid_i/lsu_valid_i: requester valids; streak_i: current LSU streak
//   grant_o: one-hot {lsu, ifu}; streak_o: streak value to store if a grant is taken
module ysyx_24100006_arb_pick #(
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  input  logic [3:0] streak_i,
  output logic [1:0] grant_o,
  output logic [3:0] streak_o
);
  localparam logic [3:0] MAX = 4'(MAX_LSU_STREAK);
  logic at_max, ifu_win, lsu_win;
  assign at_max  = streak_i == MAX;
  assign ifu_win = ifu_valid_i && (at_max || !lsu_valid_i);
  assign lsu_win = lsu_valid_i && !ifu_win;
  assign grant_o = {lsu_win, ifu_win};
  // the streak only counts LSU grants that made a waiting IFU lose
  assign streak_o = ifu_win ? 4'd0 : !lsu_win ? streak_i : !ifu_valid_i ? 4'd0 :
                    at_max ? streak_i : streak_i + 4'd1;
endmodule

// File: rtl/ysyx_24100006_mem_arbiter.sv
// ysyx_24100006_mem_arbiter: shares one memory port between IFU and LSU, one transaction at a time
//   ifu_req_*/ifu_resp_*: fetch read channel; lsu_req_*/lsu_resp_*: load/store channel
//   mem_req_*/mem_resp_*: registered memory request, combinational response routing; busy: not IDLE
module ysyx_24100006_mem_arbiter
  import ysyx_24100006_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy
);
  state_e              state_q;
  owner_e              owner_q;
  logic [3:0]          streak_q, streak_d;
  logic [1:0]          grant;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                idle, ifu_own, lsu_own;

  ysyx_24100006_arb_pick #(.MAX_LSU_STREAK(MAX_LSU_STREAK)) u_pick (
    .ifu_valid_i(ifu_req_valid),
    .lsu_valid_i(lsu_req_valid),
    .streak_i   (streak_q),
    .grant_o    (grant),
    .streak_o   (streak_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IFU;
      streak_q <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (|grant) begin
          state_q  <= ISSUE;
          owner_q  <= grant[1] ? OWN_LSU : OWN_IFU;
          streak_q <= streak_d;
          addr_q   <= grant[1] ? lsu_req_addr : ifu_req_addr;
          wen_q    <= grant[1] && lsu_req_wen;
          wdata_q  <= grant[1] ? lsu_req_wdata : '0;
          wmask_q  <= grant[1] ? lsu_req_wmask : '0;
        end
        ISSUE: if (mem_req_ready) state_q <= WAIT;
        WAIT: if (mem_resp_valid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idle           = state_q == IDLE;
  assign ifu_own        = state_q == WAIT && owner_q == OWN_IFU;
  assign lsu_own        = state_q == WAIT && owner_q == OWN_LSU;
  assign ifu_req_ready  = idle && grant[0];
  assign lsu_req_ready  = idle && grant[1];
  assign ifu_resp_valid = ifu_own && mem_resp_valid;
  assign lsu_resp_valid = lsu_own && mem_resp_valid;
  assign ifu_resp_data  = ifu_own ? mem_resp_data : '0;
  assign lsu_resp_data  = lsu_own ? mem_resp_data : '0;
  assign mem_req_valid  = state_q == ISSUE;
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign busy           = !idle;
endmodule

// File: tb/tb_ysyx_24100006_mem_arbiter.sv
// tb_ysyx_24100006_mem_arbiter: table-driven cycle vectors plus streak-order sequence
module tb_ysyx_24100006_mem_arbiter;
  typedef struct packed {
    logic rst, iv; logic [31:0] ia;
    logic lv; logic [31:0] la; logic lw; logic [31:0] ld; logic [3:0] lm;
    logic mr, mv; logic [31:0] md;
  } in_t;
  typedef struct packed {
    logic ir, lr, mqv; logic [31:0] mqa; logic mqw; logic [31:0] mqd; logic [3:0] mqm;
    logic irv; logic [31:0] ird; logic lrv; logic [31:0] lrd; logic bz;
  } out_t;
  typedef struct packed {
    logic [63:0] tag;
    in_t i;
    out_t o;
  } vec_t;

  localparam logic [31:0] IA = 32'h8000_0000, LA = 32'h8000_1810, RD = 32'h0000_0413;
  localparam logic [31:0] WD = 32'h0000_0074, WD2 = 32'h1234_5678;

  logic clock = 0, reset = 1;
  logic ifu_req_valid = 0, lsu_req_valid = 0, lsu_req_wen = 0, mem_req_ready = 0, mem_resp_valid = 0;
  logic [31:0] ifu_req_addr = 0, lsu_req_addr = 0, lsu_req_wdata = 0, mem_resp_data = 0;
  logic [3:0] lsu_req_wmask = 0;
  logic ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_req_wen, busy;
  logic [31:0] ifu_resp_data, lsu_resp_data, mem_req_addr, mem_req_wdata;
  logic [3:0] mem_req_wmask;

  int total = 0, passed = 0;
  vec_t tbl[$];

  always #5 clock = ~clock;

  ysyx_24100006_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );

  function automatic in_t fi(input logic rst, iv, input logic [31:0] ia, input logic lv,
                             input logic [31:0] la, input logic lw, input logic [31:0] ld,
                             input logic [3:0] lm, input logic mr, mv, input logic [31:0] md);
    return '{rst, iv, ia, lv, la, lw, ld, lm, mr, mv, md};
  endfunction

  function automatic out_t fo(input logic ir, lr, mqv, input logic [31:0] mqa, input logic mqw,
                              input logic [31:0] mqd, input logic [3:0] mqm, input logic irv,
                              input logic [31:0] ird, input logic lrv, input logic [31:0] lrd,
                              input logic bz);
    return '{ir, lr, mqv, mqa, mqw, mqd, mqm, irv, ird, lrv, lrd, bz};
  endfunction

  task automatic add(input logic [63:0] tag, input in_t i, input out_t o);
    tbl.push_back('{tag, i, o});
  endtask

  task automatic apply(input in_t v);
    reset = v.rst; ifu_req_valid = v.iv; ifu_req_addr = v.ia;
    lsu_req_valid = v.lv; lsu_req_addr = v.la; lsu_req_wen = v.lw;
    lsu_req_wdata = v.ld; lsu_req_wmask = v.lm;
    mem_req_ready = v.mr; mem_resp_valid = v.mv; mem_resp_data = v.md;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    out_t act;
    string order;
    int n;
    logic dual;
    add("rst",      fi(1,0,0,0,0,0,0,0,0,0,0),  fo(0,0,0,0,0,0,0,0,0,0,0,0));
    add("ifu_g",    fi(0,1,IA,0,0,0,0,0,1,0,0), fo(1,0,0,0,0,0,0,0,0,0,0,0));
    add("ifu_iss",  fi(0,0,0,0,0,0,0,0,1,0,0),  fo(0,0,1,IA,0,0,0,0,0,0,0,1));
    add("ifu_rsp",  fi(0,0,0,0,0,0,0,0,1,1,RD), fo(0,0,0,IA,0,0,0,1,RD,0,0,1));
    add("both_g",   fi(0,1,IA,1,LA,1,WD,1,1,0,0), fo(0,1,0,IA,0,0,0,0,0,0,0,0));
    add("lsu_iss",  fi(0,1,IA,0,0,0,0,0,1,0,0), fo(0,0,1,LA,1,WD,1,0,0,0,0,1));
    add("lsu_rsp",  fi(0,1,IA,0,0,0,0,0,1,1,RD), fo(0,0,0,LA,1,WD,1,0,0,1,RD,1));
    add("ifu_g2",   fi(0,1,IA,0,0,0,0,0,1,0,0), fo(1,0,0,LA,1,WD,1,0,0,0,0,0));
    add("ifu_iss2", fi(0,0,0,0,0,0,0,0,1,0,0),  fo(0,0,1,IA,0,0,0,0,0,0,0,1));
    add("ifu_rsp2", fi(0,0,0,0,0,0,0,0,1,1,RD), fo(0,0,0,IA,0,0,0,1,RD,0,0,1));
    add("lsu_g",    fi(0,1,IA,1,LA,1,WD2,4'hC,0,0,0), fo(0,1,0,IA,0,0,0,0,0,0,0,0));
    for (int k = 0; k < 5; k++)
      add("stall", fi(0,1,IA+4,1,32'h9000_0000,0,32'hFFFF_FFFF,4'hF,0,k==2,RD),
          fo(0,0,1,LA,1,WD2,4'hC,0,0,0,0,1));
    add("iss_go",   fi(0,0,0,0,0,0,0,0,1,0,0),  fo(0,0,1,LA,1,WD2,4'hC,0,0,0,0,1));
    add("wait",     fi(0,0,0,0,0,0,0,0,0,0,0),  fo(0,0,0,LA,1,WD2,4'hC,0,0,0,0,1));
    add("rst_w",    fi(1,0,0,0,0,0,0,0,0,0,0),  fo(0,0,0,LA,1,WD2,4'hC,0,0,0,0,1));
    add("late_rsp", fi(0,0,0,0,0,0,0,0,0,1,RD), fo(0,0,0,0,0,0,0,0,0,0,0,0));
    add("idle_rsp", fi(0,0,0,0,0,0,0,0,1,1,RD), fo(0,0,0,0,0,0,0,0,0,0,0,0));
    add("idle",     fi(0,0,0,0,0,0,0,0,0,0,0),  fo(0,0,0,0,0,0,0,0,0,0,0,0));

    repeat (2) @(posedge clock);
    foreach (tbl[r]) begin
      @(negedge clock);
      apply(tbl[r].i);
      #1;
      act = '{ifu_req_ready, lsu_req_ready, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
              mem_req_wmask, ifu_resp_valid, ifu_resp_data, lsu_resp_valid, lsu_resp_data, busy};
      chk($sformatf("row%0d_%s", r, tbl[r].tag), 256'(act), 256'(tbl[r].o));
    end
    chk("streak_after_reset", 256'(dut.streak_q), 256'(0));

    @(negedge clock);
    apply(fi(1,0,0,0,0,0,0,0,0,0,0));
    @(negedge clock);
    apply(fi(0,1,IA,1,LA,0,0,0,1,1,RD));
    order = "";
    n = 0;
    dual = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      #1;
      if (ifu_req_ready && lsu_req_ready) dual = 1;
      if (lsu_req_ready) begin order = {order, "L"}; n++; end
      else if (ifu_req_ready) begin order = {order, "I"}; n++; end
      @(negedge clock);
    end
    total++;
    if (order == "LLLLILLLLI") passed++;
    else $display("FAIL grant_order: got '%s' expected 'LLLLILLLLI'", order);
    chk("single_grant", 256'(dual), 256'(0));
    apply(fi(0,0,0,0,0,0,0,0,0,0,0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
